// File: rtl/serial_subtractor_ctrl_pkg.sv
// Shared state encoding and sizing helper for the bit-serial subtractor sequencer.
package serial_subtractor_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // One extra bit so the counter can represent WIDTH itself without wrapping.
  function automatic int cnt_w(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_ctrl_fullsub.sv
// One-bit full subtractor cell: diff = a - b - c_in, borrow out when the result goes negative.
module fullsubtractor (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic diff,
  output logic borrow
);

  assign diff   = a ^ b ^ c_in;
  assign borrow = (~a & b) | (~a & c_in) | (b & c_in);

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial WIDTH-bit subtractor: feeds one full-subtractor cell LSB first, one bit per clock.
module serial_subtractor_ctrl
  import serial_subtractor_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  // Handshake: start is accepted only while idle; done pulses for one cycle
  // and diff/bout stay stable from that cycle until the next completion.

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             brw;
  logic [CNT_W-1:0] cnt;
  logic             capture;
  logic             shift_en;
  logic             finish;
  logic             cell_diff;
  logic             cell_borrow;

  fullsubtractor u_fs (
    .a      (a_sr[0]),
    .b      (b_sr[0]),
    .c_in   (brw),
    .diff   (cell_diff),
    .borrow (cell_borrow)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start) next_state = S_SHIFT;
      S_SHIFT: if (cnt == CNT_LAST) next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != S_IDLE);
    capture  = (state == S_IDLE) && start;
    shift_en = (state == S_SHIFT);
    finish   = (state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      brw    <= 1'b0;
      cnt    <= '0;
      done   <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
    end else begin
      done <= finish;
      if (capture) begin
        a_sr <= a;
        b_sr <= b;
        brw  <= bin;
        cnt  <= '0;
      end else if (shift_en) begin
        // Result fills from the MSB end so bit 0 lands in place after WIDTH shifts.
        res_sr <= {cell_diff, res_sr[WIDTH-1:1]};
        brw    <= cell_borrow;
        a_sr   <= a_sr >> 1;
        b_sr   <= b_sr >> 1;
        cnt    <= cnt + 1'b1;
      end
      if (finish) begin
        diff <= res_sr;
        bout <= brw;
      end
    end
  end

endmodule
